project_cpu_2020: RTL and testbench

Minimal 16-bit accumulator CPU with a 13-bit address space. It fetches instructions from a single-port synchronous block RAM (`blram`, 8192 x 16) and executes them against one working register W. It is the top-level processing block of the project. PC and W are exported so test benches can check architectural state.

---
 rtl/project_cpu_2020.sv | 131 +++++++++++++
 tb/tb_project_cpu_2020.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/project_cpu_2020.sv
// 16-bit accumulator CPU: fetches from a synchronous block RAM and executes on W.
// Optional A==0 indirect addressing through mem[2] is enabled by PCPU_INDIRECT_EN.
module project_cpu_2020 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_fromRAM,
    output logic        wrEn,
    output logic [12:0] addr_toRAM,
    output logic [15:0] data_toRAM,
    output logic [12:0] PC,
    output logic [15:0] W
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_DECODE = 2'd1,
`ifdef PCPU_INDIRECT_EN
        S_INDIR  = 2'd2,
`endif
        S_EXEC   = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_NOR  = 3'd1,
        OP_SRRL = 3'd2,
        OP_GT   = 3'd3,
        OP_SZ   = 3'd4,
        OP_CP2W = 3'd5,
        OP_CPFW = 3'd6,
        OP_JMP  = 3'd7
    } op_e;

    state_e      state_q, state_d;
    logic [12:0] pc_q, pc_d;
    logic [15:0] w_q, w_d;
    logic [2:0]  op_q, op_d;
    logic [12:0] ea_q, ea_d;

    // Shift/rotate unit; only the low six operand bits are meaningful.
    function automatic logic [15:0] srrl(input logic [15:0] w,
                                         input logic [5:0]  m);
        logic [3:0] s;
        logic [4:0] inv;
        logic [15:0] r;
        s   = m[3:0];
        inv = 5'd16 - {1'b0, s};
        case (m[5:4])
            2'b00:   r = w >> s;
            2'b01:   r = w << s;
            2'b10:   r = (w >> s) | (w << inv);
            default: r = (w << s) | (w >> inv);
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            pc_q    <= '0;
            w_q     <= '0;
            op_q    <= '0;
            ea_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            w_q     <= w_d;
            op_q    <= op_d;
            ea_q    <= ea_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        w_d        = w_q;
        op_d       = op_q;
        ea_d       = ea_q;
        addr_toRAM = pc_q;
        wrEn       = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                addr_toRAM = pc_q;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                op_d = data_fromRAM[15:13];
`ifdef PCPU_INDIRECT_EN
                if (data_fromRAM[12:0] == 13'd0) begin
                    addr_toRAM = 13'd2;
                    state_d    = S_INDIR;
                end else
`endif
                begin
                    addr_toRAM = data_fromRAM[12:0];
                    ea_d       = data_fromRAM[12:0];
                    state_d    = S_EXEC;
                end
            end
`ifdef PCPU_INDIRECT_EN
            S_INDIR: begin
                ea_d       = data_fromRAM[12:0];
                addr_toRAM = data_fromRAM[12:0];
                state_d    = S_EXEC;
            end
`endif
            S_EXEC: begin
                addr_toRAM = ea_q;
                pc_d       = pc_q + 13'd1;
                state_d    = S_FETCH;
                unique case (op_e'(op_q))
                    OP_ADD:  w_d = w_q + data_fromRAM;
                    OP_NOR:  w_d = ~(w_q | data_fromRAM);
                    OP_SRRL: w_d = srrl(w_q, data_fromRAM[5:0]);
                    OP_GT:   w_d = {15'd0, (w_q > data_fromRAM)};
                    OP_SZ:   pc_d = pc_q + ((data_fromRAM == 16'd0) ? 13'd2 : 13'd1);
                    OP_CP2W: w_d = data_fromRAM;
                    OP_CPFW: wrEn = 1'b1;
                    OP_JMP:  pc_d = data_fromRAM[12:0];
                    default: w_d = w_q;
                endcase
            end
            default: state_d = S_FETCH;
        endcase
    end

    assign data_toRAM = w_q;
    assign PC         = pc_q;
    assign W          = w_q;

endmodule

// File: tb/tb_project_cpu_2020.sv
// Directed-program bench for project_cpu_2020 with a behavioural 8192x16 block RAM.
// Indirect-mode vectors run only when PCPU_INDIRECT_EN is defined.
module tb_project_cpu_2020;

    logic        clk;
    logic        rst;
    logic [15:0] data_fromRAM;
    logic        wrEn;
    logic [12:0] addr_toRAM;
    logic [15:0] data_toRAM;
    logic [12:0] PC;
    logic [15:0] W;

    logic [15:0] mem [0:8191];
    int          n_vec;
    int          n_err;
    int          wr_cnt;
    int          wr0;
    logic [12:0] last_pc;

`ifdef PCPU_INDIRECT_EN
    localparam int NIND = 4;
`else
    localparam int NIND = 3;
`endif

    project_cpu_2020 dut (
        .clk          (clk),
        .rst          (rst),
        .data_fromRAM (data_fromRAM),
        .wrEn         (wrEn),
        .addr_toRAM   (addr_toRAM),
        .data_toRAM   (data_toRAM),
        .PC           (PC),
        .W            (W)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        data_fromRAM <= mem[addr_toRAM];
        if (wrEn)
            mem[addr_toRAM] <= data_toRAM;
    end

    always @(negedge clk)
        if (!rst && wrEn)
            wr_cnt <= wr_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic ld(input int a, input logic [15:0] v);
        mem[a] <= v;
    endtask

    task automatic step(input int n, input logic [12:0] epc,
                        input logic [15:0] ew);
        repeat (n - 1) @(posedge clk);
        #1 check("pc_hold", {19'd0, PC}, {19'd0, last_pc});
        @(posedge clk);
        #1;
        check("pc", {19'd0, PC}, {19'd0, epc});
        check("w", {16'd0, W}, {16'd0, ew});
        last_pc = epc;
    endtask

    initial begin
        rst          = 1'b1;
        n_vec        = 0;
        n_err        = 0;
        wr_cnt       = 0;
        last_pc      = '0;
        data_fromRAM = '0;
        for (int i = 0; i < 8192; i++) mem[i] <= 16'h0000;
        #1;
        ld(0, 16'hE005); ld(5, 16'h0003);
        ld(3, 16'hE006); ld(6, 16'h000A);
        ld(10, 16'hA064); ld(11, 16'h0064);
        ld(12, 16'hA065); ld(13, 16'h0066);
        ld(14, 16'hA067); ld(15, 16'h4068);
        ld(16, 16'hA069); ld(17, 16'h406A);
        ld(18, 16'hA066); ld(19, 16'h406B);
        ld(20, 16'hA06C); ld(21, 16'h606D);
        ld(22, 16'h6066); ld(23, 16'h2064);
        ld(24, 16'h406E); ld(25, 16'h406F);
        ld(26, 16'hE070);
        ld(78, 16'h8071); ld(79, 16'hA065);
        ld(80, 16'hE072); ld(84, 16'h8073);
        ld(85, 16'hA074); ld(86, 16'hC048);
        ld(87, 16'hA064); ld(88, 16'hA048);
        ld(89, 16'hA075); ld(90, 16'hC05C);
        ld(91, 16'hA065); ld(93, 16'hA000);
        ld(100, 16'h0010); ld(101, 16'hFFFF);
        ld(102, 16'h0001); ld(103, 16'h0040);
        ld(104, 16'h0003); ld(105, 16'h00DF);
        ld(106, 16'h0038); ld(107, 16'h0017);
        ld(108, 16'h0005); ld(109, 16'h0004);
        ld(110, 16'h0024); ld(111, 16'hFFC2);
        ld(112, 16'h004E); ld(113, 16'h0000);
        ld(114, 16'h0054); ld(115, 16'h0007);
        ld(116, 16'h00FF); ld(117, 16'hA064);

        repeat (3) @(posedge clk);
        #1;
        check("rst_pc", {19'd0, PC}, 32'd0);
        check("rst_w", {16'd0, W}, 32'd0);
        check("rst_wren", {31'd0, wrEn}, 32'd0);
        check("rst_addr", {19'd0, addr_toRAM}, 32'd0);
        @(negedge clk) rst = 1'b0;

        step(3, 13'd3, 16'h0000);
        step(3, 13'd10, 16'h0000);
        step(3, 13'd11, 16'd16);
        step(3, 13'd12, 16'd32);
        step(3, 13'd13, 16'hFFFF);
        step(3, 13'd14, 16'h0000);
        step(3, 13'd15, 16'h0040);
        step(3, 13'd16, 16'h0008);
        step(3, 13'd17, 16'h00DF);
        step(3, 13'd18, 16'hDF00);
        step(3, 13'd19, 16'h0001);
        step(3, 13'd20, 16'h0080);
        step(3, 13'd21, 16'h0005);
        step(3, 13'd22, 16'h0001);
        step(3, 13'd23, 16'h0000);
        step(3, 13'd24, 16'hFFEF);
        step(3, 13'd25, 16'hFFFE);
        step(3, 13'd26, 16'h3FFF);
        step(3, 13'd78, 16'h3FFF);
        step(3, 13'd80, 16'h3FFF);
        step(3, 13'd84, 16'h3FFF);
        step(3, 13'd85, 16'h3FFF);
        step(3, 13'd86, 16'h00FF);
        wr0 = wr_cnt;
        step(3, 13'd87, 16'h00FF);
        check("cpfw_once", wr_cnt - wr0, 32'd1);
        check("mem72", {16'd0, mem[72]}, 32'h00FF);
        step(3, 13'd88, 16'd16);
        step(3, 13'd89, 16'h00FF);
        step(3, 13'd90, 16'hA064);
        step(3, 13'd91, 16'hA064);
        step(3, 13'd92, 16'hFFFF);
        step(3, 13'd93, 16'd16);
        step(NIND, 13'd94, 16'hE005);
        check("wr_total", wr_cnt, 32'd2);

`ifdef PCPU_INDIRECT_EN
        rst = 1'b1;
        ld(0, 16'hA078); ld(120, 16'hDEAF);
        ld(1, 16'hC000); ld(2, 16'h0093);
        ld(147, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        last_pc = '0;
        step(3, 13'd1, 16'hDEAF);
        wr0 = wr_cnt;
        repeat (3) @(posedge clk);
        #1;
        check("ind_pc_hold", {19'd0, PC}, 32'd1);
        check("ind_no_wr_yet", wr_cnt - wr0, 32'd0);
        @(posedge clk);
        #1;
        check("ind_pc", {19'd0, PC}, 32'd2);
        check("ind_wr", wr_cnt - wr0, 32'd1);
        check("mem147", {16'd0, mem[147]}, 32'h0000DEAF);

        rst = 1'b1;
        ld(147, 16'h0000);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        last_pc = '0;
        step(3, 13'd1, 16'hDEAF);
        wr0 = wr_cnt;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("abort_pc", {19'd0, PC}, 32'd0);
        check("abort_w", {16'd0, W}, 32'd0);
        check("abort_wren", {31'd0, wrEn}, 32'd0);
        check("abort_nowr", wr_cnt - wr0, 32'd0);
        check("abort_mem147", {16'd0, mem[147]}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
